// File: rtl/pll_cfg_reg_bank.sv
// PLL configuration register bank: host-side register file plus a programming FSM
// that snapshots one word and shifts it MSB-first to the PLL over sclk/sdata/sload.
module pll_cfg_reg_bank #(
   parameter int DATA_W   = 43,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2,
   parameter int CLK_DIV  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              prog_start,
   input  logic [ADDR_W-1:0] prog_addr,
   output logic              prog_busy,
   output logic              prog_done,
   output logic              pll_sclk,
   output logic              pll_sdata,
   output logic              pll_sload
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] LATCH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] shift_reg;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [1:0]        state;

   // Addresses beyond NUM_REGS decode to no word and read back as zero.
   function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
      word_at = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a == ADDR_W'(i)) begin
            word_at = regs[i];
         end
      end
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && wr_addr == ADDR_W'(i)) begin
               regs[i] <= wr_data;
            end
         end
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= word_at(rd_addr);
         end
      end
   end

   // Each bit period is CLK_DIV low cycles then CLK_DIV high cycles; sdata
   // only changes on the edge that starts a low phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         prog_busy <= 1'b0;
         prog_done <= 1'b0;
         pll_sclk  <= 1'b0;
         pll_sdata <= 1'b0;
         pll_sload <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               prog_done <= 1'b0;
               if (prog_start) begin
                  shift_reg <= word_at(prog_addr);
                  pll_sdata <= word_at(prog_addr) >> (DATA_W - 1) != '0;
                  pll_sclk  <= 1'b0;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  prog_busy <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!pll_sclk) begin
                     pll_sclk <= 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     pll_sclk  <= 1'b0;
                     pll_sdata <= 1'b0;
                     pll_sload <= 1'b1;
                     state     <= LATCH;
                  end else begin
                     pll_sclk  <= 1'b0;
                     pll_sdata <= shift_reg[DATA_W-2];
                     shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                     bit_cnt   <= bit_cnt + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            LATCH: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt   <= '0;
                  pll_sload <= 1'b0;
                  prog_busy <= 1'b0;
                  prog_done <= 1'b1;
                  state     <= DONE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: begin
               prog_done <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_cfg_reg_bank.sv
// Directed bench for pll_cfg_reg_bank: a default instance and a NUM_REGS=5/CLK_DIV=1
// instance, with read and serial-bit scoreboards.
module tb_pll_cfg_reg_bank;

   localparam int DW = 43;
   localparam logic [DW-1:0] PATTERN = 43'h2AA_AAAA_AAAA;
   localparam logic [DW-1:0] WORD_B  = 43'h5A5_1234_5678;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sel = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0, prog_start = 1'b0;
   logic [2:0]    wr_addr = '0, rd_addr = '0, prog_addr = '0;
   logic [DW-1:0] wr_data = '0;

   logic [DW-1:0] a_rd_data, b_rd_data, o_rd_data;
   logic a_rd_valid, a_busy, a_done, a_sclk, a_sdata, a_sload;
   logic b_rd_valid, b_busy, b_done, b_sclk, b_sdata, b_sload;
   logic o_rd_valid, o_busy, o_done, o_sclk, o_sdata, o_sload;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] rd_q [$];
   logic          bit_q [$];

   always #5 clk = ~clk;

   pll_cfg_reg_bank dut_a (
      .clk(clk), .rst(rst),
      .wr_en(wr_en & ~sel), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
      .rd_en(rd_en & ~sel), .rd_addr(rd_addr[1:0]),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid),
      .prog_start(prog_start & ~sel), .prog_addr(prog_addr[1:0]),
      .prog_busy(a_busy), .prog_done(a_done),
      .pll_sclk(a_sclk), .pll_sdata(a_sdata), .pll_sload(a_sload)
   );

   pll_cfg_reg_bank #(.DATA_W(DW), .NUM_REGS(5), .ADDR_W(3), .CLK_DIV(1)) dut_b (
      .clk(clk), .rst(rst),
      .wr_en(wr_en & sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en & sel), .rd_addr(rd_addr),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .prog_start(prog_start & sel), .prog_addr(prog_addr),
      .prog_busy(b_busy), .prog_done(b_done),
      .pll_sclk(b_sclk), .pll_sdata(b_sdata), .pll_sload(b_sload)
   );

   assign o_rd_data  = sel ? b_rd_data  : a_rd_data;
   assign o_rd_valid = sel ? b_rd_valid : a_rd_valid;
   assign o_busy     = sel ? b_busy     : a_busy;
   assign o_done     = sel ? b_done     : a_done;
   assign o_sclk     = sel ? b_sclk     : a_sclk;
   assign o_sdata    = sel ? b_sdata    : a_sdata;
   assign o_sload    = sel ? b_sload    : a_sload;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic we, input logic [2:0] wa, input logic [DW-1:0] wd,
                                 input logic re, input logic [2:0] ra);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = ra;
   endtask

   // Read with optional same-edge write; expected value is queued before the edge.
   task automatic read_check(input string tag, input logic [2:0] ra, input logic [DW-1:0] exp,
                             input logic we, input logic [DW-1:0] wd);
      logic [DW-1:0] e;
      rd_q.push_back(exp);
      apply_stimulus(we, ra, wd, 1'b1, ra);
      cycle();
      apply_stimulus(1'b0, 3'd0, '0, 1'b0, 3'd0);
      check_output({tag, "_valid"}, 64'(o_rd_valid), 64'd1);
      e = rd_q.pop_front();
      check_output({tag, "_data"}, 64'(o_rd_data), 64'(e));
      cycle();
      check_output({tag, "_pulse"}, 64'(o_rd_valid), 64'd0);
   endtask

   task automatic write_word(input logic [2:0] wa, input logic [DW-1:0] wd);
      apply_stimulus(1'b1, wa, wd, 1'b0, 3'd0);
      cycle();
      apply_stimulus(1'b0, 3'd0, '0, 1'b0, 3'd0);
   endtask

   // Runs one programming sequence, scoring every bit sampled on sclk rising edges.
   task automatic prog_run(input string tag, input logic [2:0] pa, input logic [DW-1:0] word,
                           input int exp_busy, input int exp_sload, input bit interfere,
                           input int abort_bit);
      int busy_cnt = 0, rises = 0, sload_cnt = 0, extra = 0;
      bit prev_sclk = 1'b0, done_seen = 1'b0;
      logic b;
      bit_q.delete();
      for (int i = DW - 1; i >= 0; i--) bit_q.push_back(word[i]);
      prog_addr = pa;
      prog_start = 1'b1;
      cycle();
      prog_start = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         wr_en = 1'b0;
         prog_start = 1'b0;
         if (o_done) begin
            done_seen = 1'b1;
            check_output({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
            break;
         end
         if (o_busy) busy_cnt++;
         if (o_sload) sload_cnt++;
         if (o_sclk && !prev_sclk) begin
            rises++;
            if (bit_q.size() > 0) begin
               b = bit_q.pop_front();
               check_output({tag, "_bit"}, 64'(o_sdata), 64'(b));
            end
         end
         prev_sclk = o_sclk;
         if (abort_bit >= 0 && rises == abort_bit + 1) begin
            rst = 1'b1;
            cycle();
            rst = 1'b0;
            check_output({tag, "_abort_sclk"}, 64'(o_sclk), 64'd0);
            check_output({tag, "_abort_sdata"}, 64'(o_sdata), 64'd0);
            check_output({tag, "_abort_sload"}, 64'(o_sload), 64'd0);
            check_output({tag, "_abort_busy"}, 64'(o_busy), 64'd0);
            for (int k = 0; k < 20; k++) begin
               cycle();
               if (o_done || o_busy) extra++;
            end
            check_output({tag, "_abort_quiet"}, 64'(extra), 64'd0);
            bit_q.delete();
            return;
         end
         if (interfere && busy_cnt == 100) begin
            apply_stimulus(1'b1, pa, '0, 1'b0, 3'd0);
            prog_start = 1'b1;
         end
         cycle();
      end
      wr_en = 1'b0;
      prog_start = 1'b0;
      check_output({tag, "_done_seen"}, 64'(done_seen), 64'd1);
      check_output({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
      check_output({tag, "_rises"}, 64'(rises), 64'(DW));
      check_output({tag, "_sload_cycles"}, 64'(sload_cnt), 64'(exp_sload));
      check_output({tag, "_bits_left"}, 64'(bit_q.size()), 64'd0);
      cycle();
      check_output({tag, "_done_pulse"}, 64'(o_done), 64'd0);
      for (int k = 0; k < 20; k++) begin
         if (o_busy || o_done) extra++;
         cycle();
      end
      check_output({tag, "_no_second_seq"}, 64'(extra), 64'd0);
   endtask

   initial begin
      // Reset for two cycles, then every output must be idle.
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      check_output("rst_rd_valid", 64'(o_rd_valid), 64'd0);
      check_output("rst_rd_data", 64'(o_rd_data), 64'd0);
      check_output("rst_busy", 64'(o_busy), 64'd0);
      check_output("rst_done", 64'(o_done), 64'd0);
      check_output("rst_sclk", 64'(o_sclk), 64'd0);
      check_output("rst_sdata", 64'(o_sdata), 64'd0);
      check_output("rst_sload", 64'(o_sload), 64'd0);
      for (int i = 0; i < 4; i++) read_check("rst_read", 3'(i), '0, 1'b0, '0);

      // Write then read back; same-edge write/read returns the old word.
      write_word(3'd2, PATTERN);
      read_check("rd_after_wr", 3'd2, PATTERN, 1'b0, '0);
      read_check("rd_same_edge", 3'd2, PATTERN, 1'b1, 43'h1);
      read_check("rd_new_val", 3'd2, 43'h1, 1'b0, '0);
      write_word(3'd2, PATTERN);

      // Full sequence with a mid-flight write and ignored prog_start.
      prog_run("prog_a", 3'd2, PATTERN, DW * 8 + 4, 4, 1'b1, -1);
      read_check("rd_after_interfere", 3'd2, '0, 1'b0, '0);

      // Abort at bit 20, then rerun a full sequence.
      write_word(3'd1, PATTERN);
      prog_run("abort_a", 3'd1, PATTERN, 0, 0, 1'b0, 20);
      write_word(3'd3, WORD_B);
      prog_run("rerun_a", 3'd3, WORD_B, DW * 8 + 4, 4, 1'b0, -1);

      // Second configuration: out-of-range address and CLK_DIV=1 timing.
      sel = 1'b1;
      cycle();
      write_word(3'd6, PATTERN);
      read_check("b_rd_oob", 3'd6, '0, 1'b0, '0);
      read_check("b_rd_alias", 3'd2, '0, 1'b0, '0);
      write_word(3'd4, WORD_B);
      read_check("b_rd_4", 3'd4, WORD_B, 1'b0, '0);
      prog_run("prog_b", 3'd4, WORD_B, DW * 2 + 1, 1, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
